// File: rtl/spi_ram_pkg.sv
//==============================================================================
// Module : spi_ram_pkg
// Brief  : Shared command encodings and FSM state codes for the SPI RAM slave.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RECV    = 3'd1;
    localparam state_t ST_EXEC    = 3'd2;
    localparam state_t ST_READOUT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/spi_sp_ram.sv
//==============================================================================
// Module : spi_sp_ram
// Brief  : Single-port RAM, registered read data, one-cycle read latency.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_sp_ram #(
    parameter int WIDTH     = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout
);

    logic [WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [WIDTH-1:0] r_dout;

    // Array and output register intentionally carry no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= din;
            end else begin
                r_dout <= r_mem[addr];
            end
        end
    end

    assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/spi_slave_ram_burst.sv
//==============================================================================
// Module : spi_slave_ram_burst
// Brief  : SPI slave fronting a single-port RAM with burst address auto-increment.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_slave_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int N      = WIDTH + 2;
    localparam int CNT_W  = $clog2(N + 1);

    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_rx_last  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  c_tx_end   = CNT_W'(WIDTH);
    localparam logic [WIDTH:0]    c_depth    = (WIDTH + 1)'(MEM_DEPTH);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [N-1:0]        r_shift;
    logic [WIDTH-1:0]    r_tx;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_miso;
    logic                r_frame_err;

    logic [1:0]          w_cmd;
    logic [WIDTH-1:0]    w_payload;
    logic                w_addr_bad;
    logic                w_ram_en;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [WIDTH-1:0]    w_ram_dout;

    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a);
        return (a == c_last) ? '0 : a + 1'b1;
    endfunction

    assign w_cmd      = r_shift[N-1 -: 2];
    assign w_payload  = r_shift[WIDTH-1:0];
    assign w_addr_bad = ({1'b0, w_payload} >= c_depth);

    // RAM is touched only in the execute cycle, so a reset or abort can never commit a write.
    assign w_ram_en   = (r_state == ST_EXEC) && ((w_cmd == CMD_WR_DATA) || (w_cmd == CMD_RD_DATA));
    assign w_ram_we   = (w_cmd == CMD_WR_DATA);
    assign w_ram_addr = w_ram_we ? r_wr_addr : r_rd_addr;

    spi_sp_ram #(
        .WIDTH     (WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (w_payload),
        .dout (w_ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_miso      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    r_cnt  <= '0;
                    if (!SS_n) begin
                        r_state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (SS_n) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_shift <= {r_shift[N-2:0], MOSI};
                        if (r_cnt == c_rx_last) begin
                            r_state <= ST_EXEC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    case (w_cmd)
                        CMD_WR_ADDR: begin
                            if (w_addr_bad) r_frame_err <= 1'b1;
                            else            r_wr_addr   <= w_payload[ADDR_W-1:0];
                        end
                        CMD_WR_DATA: begin
                            if (AUTO_INC != 0) r_wr_addr <= f_next(r_wr_addr);
                        end
                        CMD_RD_ADDR: begin
                            if (w_addr_bad) r_frame_err <= 1'b1;
                            else            r_rd_addr   <= w_payload[ADDR_W-1:0];
                        end
                        default: begin
                            if (AUTO_INC != 0) r_rd_addr <= f_next(r_rd_addr);
                        end
                    endcase
                    if (SS_n)                          r_state <= ST_IDLE;
                    else if (w_cmd == CMD_RD_DATA)     r_state <= ST_READOUT;
                    else                               r_state <= ST_DONE;
                end
                ST_READOUT: begin
                    if (SS_n) begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_miso <= w_ram_dout[WIDTH-1];
                        r_tx   <= w_ram_dout << 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end else if (r_cnt == c_tx_end) begin
                        r_miso  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_miso <= r_tx[WIDTH-1];
                        r_tx   <= r_tx << 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (SS_n) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign MISO      = r_miso;
    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ram_burst.sv
//==============================================================================
// Module : tb_spi_slave_ram_burst
// Brief  : Directed and random frames against a behavioural SPI-RAM model.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave_ram_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ss_n = 2'b11;
    logic [1:0] mosi = 2'b00;
    wire  [1:0] miso;
    wire  [1:0] busy;
    wire  [1:0] ferr;

    int n_assert = 0;
    int n_fail   = 0;

    int         depth [2] = '{256, 200};
    int         ainc  [2] = '{1, 0};
    int         mwr   [2] = '{0, 0};
    int         mrd   [2] = '{0, 0};
    logic [7:0] mmem  [2][256];
    bit         mknown[2][256];

    always #5 clk = ~clk;

    spi_slave_ram_burst #(.WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .busy(busy[0]), .frame_err(ferr[0])
    );

    spi_slave_ram_burst #(.WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(0)) dut1 (
        .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .busy(busy[1]), .frame_err(ferr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Spec-level model: address registers are plain integers, wrap by modulo.
    task automatic model(input int s, input logic [1:0] cmd, input logic [7:0] pl,
                         output logic err, output logic [7:0] exp, output bit known);
        err = 1'b0; exp = 8'h00; known = 1'b0;
        case (cmd)
            2'b00: if (int'(pl) >= depth[s]) err = 1'b1; else mwr[s] = int'(pl);
            2'b01: begin
                mmem[s][mwr[s]] = pl; mknown[s][mwr[s]] = 1'b1;
                if (ainc[s] != 0) mwr[s] = (mwr[s] + 1) % depth[s];
            end
            2'b10: if (int'(pl) >= depth[s]) err = 1'b1; else mrd[s] = int'(pl);
            default: begin
                exp = mmem[s][mrd[s]]; known = mknown[s][mrd[s]];
                if (ainc[s] != 0) mrd[s] = (mrd[s] + 1) % depth[s];
            end
        endcase
    endtask

    task automatic frame(input int s, input logic [1:0] cmd, input logic [7:0] pl,
                         input logic exp_err, output logic [7:0] rd);
        logic [9:0] f;
        f  = {cmd, pl};
        rd = 8'h00;
        @(negedge clk); ss_n[s] = 1'b0; mosi[s] = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); mosi[s] = f[9-i];
            @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("frame_err_exec", {31'd0, ferr[s]}, {31'd0, exp_err});
        if (cmd == 2'b11) begin
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); @(negedge clk);
                rd[7-k] = miso[s];
            end
            @(posedge clk); @(negedge clk);
            chk("miso_idle_after_lsb", {31'd0, miso[s]}, 32'd0);
        end
        chk("busy_in_frame", {31'd0, busy[s]}, 32'd1);
        ss_n[s] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("busy_after_frame", {31'd0, busy[s]}, 32'd0);
    endtask

    task automatic do_op(input int s, input logic [1:0] cmd, input logic [7:0] pl,
                         output logic [7:0] rd);
        logic       err;
        logic [7:0] exp;
        bit         known;
        model(s, cmd, pl, err, exp, known);
        frame(s, cmd, pl, err, rd);
        if (cmd == 2'b11 && known) chk("rd_data_model", {24'd0, rd}, {24'd0, exp});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [9:0] f;

        repeat (2) @(negedge clk);
        chk("reset_miso",  {30'd0, miso}, 32'd0);
        chk("reset_busy",  {30'd0, busy}, 32'd0);
        chk("reset_ferr",  {30'd0, ferr}, 32'd0);
        rst = 1'b0;

        // Plan 1-3: wrap of wr_addr and rd_addr at the top of memory
        do_op(0, 2'b00, 8'hFF, rd);
        do_op(0, 2'b01, 8'hA5, rd);
        do_op(0, 2'b01, 8'h3C, rd);
        do_op(0, 2'b10, 8'hFF, rd);
        do_op(0, 2'b11, 8'h00, rd);
        chk("plan3_rd_ff", {24'd0, rd}, 32'h0000_00A5);
        do_op(0, 2'b11, 8'h00, rd);
        chk("plan3_rd_00", {24'd0, rd}, 32'h0000_003C);

        // Plan 4: abort after 5 bits of a WR_DATA frame
        f = {2'b01, 8'hE7};
        @(negedge clk); ss_n[0] = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mosi[0] = f[9-i];
            @(posedge clk);
        end
        @(negedge clk); ss_n[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("abort_ferr", {31'd0, ferr[0]}, 32'd1);
        chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("abort_ferr_pulse", {31'd0, ferr[0]}, 32'd0);
        do_op(0, 2'b01, 8'h5A, rd);
        do_op(0, 2'b10, 8'h00, rd);
        do_op(0, 2'b11, 8'h00, rd);
        chk("abort_mem0", {24'd0, rd}, 32'h0000_003C);
        do_op(0, 2'b11, 8'h00, rd);
        chk("abort_mem1", {24'd0, rd}, 32'h0000_005A);

        // Plan 5: reset in the middle of reading 0x3C
        do_op(0, 2'b10, 8'h00, rd);
        f = {2'b11, 8'h00};
        @(negedge clk); ss_n[0] = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); mosi[0] = f[9-i];
            @(posedge clk);
        end
        @(posedge clk);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        chk("pre_rst_miso", {31'd0, miso[0]}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_miso", {31'd0, miso[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        #1 rst = 1'b0; ss_n[0] = 1'b1;
        mwr[0] = 0; mrd[0] = 0;
        do_op(0, 2'b11, 8'h00, rd);
        chk("post_rst_mem0", {24'd0, rd}, 32'h0000_003C);
        do_op(0, 2'b01, 8'h66, rd);
        do_op(0, 2'b10, 8'h00, rd);
        do_op(0, 2'b11, 8'h00, rd);
        chk("post_rst_wr0", {24'd0, rd}, 32'h0000_0066);

        // Plan 6: non-power-of-two depth, no auto-increment, range error
        do_op(1, 2'b00, 8'd199, rd);
        do_op(1, 2'b01, 8'h12, rd);
        do_op(1, 2'b01, 8'h34, rd);
        do_op(1, 2'b00, 8'd250, rd);
        do_op(1, 2'b01, 8'h56, rd);
        do_op(1, 2'b10, 8'd199, rd);
        do_op(1, 2'b11, 8'h00, rd);
        chk("d200_mem199", {24'd0, rd}, 32'h0000_0056);
        do_op(1, 2'b10, 8'd230, rd);
        do_op(1, 2'b11, 8'h00, rd);
        chk("d200_rd_hold", {24'd0, rd}, 32'h0000_0056);

        // Random phase: fill dut0 in one burst, then mixed random frames
        do_op(0, 2'b00, 8'h00, rd);
        for (int i = 0; i < 256; i++) do_op(0, 2'b01, 8'($urandom), rd);
        for (int i = 0; i < 100; i++) do_op(0, 2'($urandom_range(0, 3)), 8'($urandom), rd);
        for (int i = 0; i < 60; i++)  do_op(1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
